// File: rtl/gemm_result_writer.sv
// Output stage of the GEMM array: latches one accumulator tile, requantizes it
// (arithmetic shift + signed saturation) and drains it one row per beat.
module gemm_result_writer #(
   parameter int PE_ROWS    = 8,
   parameter int PE_COLS    = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              tile_valid,
   output logic                              tile_ready,
   input  logic [ADDR_WIDTH-1:0]             tile_addr,
   input  logic [ACC_WIDTH*PE_ROWS*PE_COLS-1:0] tile_data,
   input  logic [4:0]                        cfg_shift,
   input  logic [ADDR_WIDTH-1:0]             cfg_row_stride,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ADDR_WIDTH-1:0]             out_addr,
   output logic [OUT_WIDTH*PE_COLS-1:0]      out_data,
   output logic                              out_last,
   output logic                              busy,
   output logic [31:0]                       tiles_done,
   output logic [15:0]                       sat_rows
);

   localparam int ROW_W    = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;
   localparam int ROW_BITS = ACC_WIDTH * PE_COLS;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                              state_reg, state_next;
   logic [ROW_W-1:0]                    row_reg;
   logic [ACC_WIDTH*PE_ROWS*PE_COLS-1:0] tile_buf_reg;
   logic [ADDR_WIDTH-1:0]               addr_reg;
   logic [ADDR_WIDTH-1:0]               stride_reg;
   logic [4:0]                          shift_reg;
   logic [31:0]                         tiles_done_reg;
   logic [15:0]                         sat_rows_reg;

   logic                                accept;
   logic                                beat_fire;
   logic                                last_row;
   logic                                row_sat;
   logic [PE_COLS-1:0]                  col_sat;
   logic [ROW_BITS-1:0]                 row_vec [PE_ROWS];
   logic [ROW_BITS-1:0]                 cur_row;

   genvar gi;

   assign accept    = tile_valid && (state_reg == IDLE);
   assign beat_fire = out_valid && out_ready;
   assign last_row  = (row_reg == ROW_W'(PE_ROWS - 1));
   assign row_sat   = |col_sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (tile_valid) state_next = DRAIN;
         DRAIN:   if (out_ready && last_row) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tile_ready = (state_reg == IDLE);
      busy       = (state_reg == DRAIN);
      out_valid  = (state_reg == DRAIN);
      out_last   = (state_reg == DRAIN) && last_row;
   end

   // Row address is accumulated rather than multiplied; wraps naturally mod 2^ADDR_WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_reg        <= '0;
         tile_buf_reg   <= '0;
         addr_reg       <= '0;
         stride_reg     <= '0;
         shift_reg      <= '0;
         tiles_done_reg <= '0;
         sat_rows_reg   <= '0;
      end else if (accept) begin
         row_reg      <= '0;
         tile_buf_reg <= tile_data;
         addr_reg     <= tile_addr;
         stride_reg   <= cfg_row_stride;
         shift_reg    <= cfg_shift;
      end else if (beat_fire) begin
         addr_reg <= addr_reg + stride_reg;
         if (last_row) begin
            row_reg        <= '0;
            tiles_done_reg <= tiles_done_reg + 32'd1;
         end else begin
            row_reg <= row_reg + 1'b1;
         end
         if (row_sat && (sat_rows_reg != 16'hFFFF))
            sat_rows_reg <= sat_rows_reg + 16'd1;
      end
   end

   generate
      for (gi = 0; gi < PE_ROWS; gi++) begin : g_row
         assign row_vec[gi] = tile_buf_reg[gi*ROW_BITS +: ROW_BITS];
      end
   endgenerate

   assign cur_row = row_vec[row_reg];

   // >>> on a signed operand floors toward -inf and sign-fills for large shifts.
   generate
      for (gi = 0; gi < PE_COLS; gi++) begin : g_col
         logic signed [ACC_WIDTH-1:0] acc;
         logic signed [ACC_WIDTH-1:0] shifted;
         logic                        over;
         logic                        under;
         assign acc         = cur_row[gi*ACC_WIDTH +: ACC_WIDTH];
         assign shifted     = acc >>> shift_reg;
         assign over        = (shifted > SAT_MAX);
         assign under       = (shifted < SAT_MIN);
         assign col_sat[gi] = over || under;
         assign out_data[gi*OUT_WIDTH +: OUT_WIDTH] =
            over  ? SAT_MAX[OUT_WIDTH-1:0] :
            under ? SAT_MIN[OUT_WIDTH-1:0] :
                    shifted[OUT_WIDTH-1:0];
      end
   endgenerate

   assign out_addr   = addr_reg;
   assign tiles_done = tiles_done_reg;
   assign sat_rows   = sat_rows_reg;

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed bench for gemm_result_writer: drain, requantize, backpressure,
// tile-while-busy, reset mid-drain and address wrap.
module tb_gemm_result_writer;

   logic          clk = 1'b0;
   logic          rst;
   logic          tile_valid, tile_ready;
   logic [31:0]   tile_addr, cfg_row_stride, out_addr, tiles_done;
   logic [2047:0] tile_data, tdata, ndata;
   logic [4:0]    cfg_shift;
   logic          out_valid, out_ready, out_last, busy;
   logic [127:0]  out_data;
   logic [15:0]   sat_rows;

   logic [127:0]  beat_data [8];
   logic [31:0]   beat_addr [8];
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   gemm_result_writer dut (
      .clk(clk), .rst(rst),
      .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_addr(tile_addr), .tile_data(tile_data),
      .cfg_shift(cfg_shift), .cfg_row_stride(cfg_row_stride),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
      .busy(busy), .tiles_done(tiles_done), .sat_rows(sat_rows)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rq(input logic [31:0] a, input logic [4:0] sh);
      longint v;
      v = longint'($signed(a));
      v = v >>> sh;
      if (v > 64'sd32767)  return 16'h7FFF;
      if (v < -64'sd32768) return 16'h8000;
      return v[15:0];
   endfunction

   function automatic logic [127:0] model_row(input int r, input logic [4:0] sh);
      logic [127:0] row;
      row = '0;
      for (int j = 0; j < 8; j++)
         row[j*16 +: 16] = rq(tdata[(r*8+j)*32 +: 32], sh);
      return row;
   endfunction

   task automatic fill_ramp();
      tdata = '0;
      for (int r = 0; r < 8; r++)
         for (int j = 0; j < 8; j++)
            tdata[(r*8+j)*32 +: 32] = 32'(16*r + j);
   endtask

   // Called at a negedge with the DUT idle; returns at the bubble cycle after the last beat.
   task automatic run_tile(input logic [31:0] base, input logic [31:0] stride,
                           input logic [4:0] sh, input int stall_row, input int stall_n,
                           input logic hold, input logic [31:0] nb);
      logic [127:0] exp_row;
      logic [31:0]  exp_addr;
      tile_data = tdata; tile_addr = base; cfg_row_stride = stride; cfg_shift = sh;
      tile_valid = 1'b1; out_ready = 1'b1;
      chk("ready_before_accept", 128'(tile_ready), 128'(1));
      @(negedge clk);
      tile_valid = 1'b0;
      if (!hold) begin
         tile_data = ~tdata; tile_addr = ~base; cfg_row_stride = 32'h0BAD_0000; cfg_shift = ~sh;
      end
      for (int r = 0; r < 8; r++) begin
         exp_row  = model_row(r, sh);
         exp_addr = base + 32'(r) * stride;
         if (hold && r == 1) begin
            tile_valid = 1'b1; tile_data = ndata; tile_addr = nb;
         end
         if (r == stall_row) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               chk("stall_valid", 128'(out_valid), 128'(1));
               chk("stall_addr", 128'(out_addr), 128'(exp_addr));
               chk("stall_data", out_data, exp_row);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
         chk("beat_valid", 128'(out_valid), 128'(1));
         chk("beat_busy", 128'(busy), 128'(1));
         chk("beat_tile_ready", 128'(tile_ready), 128'(0));
         chk("beat_addr", 128'(out_addr), 128'(exp_addr));
         chk("beat_data", out_data, exp_row);
         chk("beat_last", 128'(out_last), 128'(r == 7));
         beat_data[r] = out_data;
         beat_addr[r] = out_addr;
         @(negedge clk);
      end
      chk("bubble_valid", 128'(out_valid), 128'(0));
      chk("bubble_busy", 128'(busy), 128'(0));
      chk("bubble_ready", 128'(tile_ready), 128'(1));
   endtask

   initial begin
      rst = 1'b1; tile_valid = 1'b0; out_ready = 1'b0;
      tile_addr = '0; tile_data = '0; cfg_shift = '0; cfg_row_stride = '0;
      tdata = '0; ndata = '0;
      repeat (2) @(negedge clk);
      chk("rst_tile_ready", 128'(tile_ready), 128'(1));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_out_addr", 128'(out_addr), 128'(0));
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_tiles_done", 128'(tiles_done), 128'(0));
      chk("rst_sat_rows", 128'(sat_rows), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // Basic drain
      fill_ramp();
      run_tile(32'h1000, 32'h10, 5'd0, -1, 0, 1'b0, 32'h0);
      chk("t1_row2_el3", 128'(beat_data[2][48 +: 16]), 128'(16'h0023));
      chk("t1_addr7", 128'(beat_addr[7]), 128'(32'h1070));
      chk("t1_tiles_done", 128'(tiles_done), 128'(1));
      chk("t1_sat_rows", 128'(sat_rows), 128'(0));

      // Requantize and saturate; row 0 stalled so sat_rows must count it only once
      tdata = '0;
      tdata[31:0] = 32'h0001_2345; tdata[63:32] = 32'hFFFE_7960;
      tdata[95:64] = 32'hFFFF_FFFF; tdata[127:96] = 32'h0000_7FFF;
      run_tile(32'h3000, 32'h40, 5'd0, 0, 3, 1'b0, 32'h0);
      chk("t2_row0_sh0", beat_data[0], {64'h0, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF});
      chk("t2_sat_rows_sh0", 128'(sat_rows), 128'(1));
      run_tile(32'h3000, 32'h40, 5'd4, -1, 0, 1'b0, 32'h0);
      chk("t2_row0_sh4", beat_data[0], {64'h0, 16'h07FF, 16'hFFFF, 16'hE796, 16'h1234});
      chk("t2_sat_rows_sh4", 128'(sat_rows), 128'(1));
      chk("t2_tiles_done", 128'(tiles_done), 128'(3));

      // Backpressure on row 3
      fill_ramp();
      run_tile(32'h1000, 32'h10, 5'd0, 3, 5, 1'b0, 32'h0);
      chk("t3_addr3", 128'(beat_addr[3]), 128'(32'h1030));
      chk("t3_addr4", 128'(beat_addr[4]), 128'(32'h1040));
      chk("t3_tiles_done", 128'(tiles_done), 128'(4));

      // Second tile offered while busy
      for (int k = 0; k < 64; k++) ndata[k*32 +: 32] = 32'(1000 + k);
      run_tile(32'h1000, 32'h10, 5'd0, -1, 0, 1'b1, 32'h2000);
      chk("t4_first_row7_el0", 128'(beat_data[7][15:0]), 128'(16'h0070));
      tdata = ndata;
      run_tile(32'h2000, 32'h10, 5'd0, -1, 0, 1'b0, 32'h0);
      chk("t4_second_addr0", 128'(beat_addr[0]), 128'(32'h2000));
      chk("t4_second_row0_el1", 128'(beat_data[0][31:16]), 128'(16'd1001));
      chk("t4_tiles_done", 128'(tiles_done), 128'(6));

      // Reset during row 4
      fill_ramp();
      tile_data = tdata; tile_addr = 32'h5000; cfg_row_stride = 32'h10; cfg_shift = 5'd0;
      tile_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      tile_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_at_row4_addr", 128'(out_addr), 128'(32'h5040));
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", 128'(out_valid), 128'(0));
      chk("t5_rst_busy", 128'(busy), 128'(0));
      chk("t5_rst_last", 128'(out_last), 128'(0));
      chk("t5_rst_tile_ready", 128'(tile_ready), 128'(1));
      chk("t5_rst_tiles_done", 128'(tiles_done), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_tile(32'h6000, 32'h20, 5'd1, -1, 0, 1'b0, 32'h0);
      chk("t5_after_addr0", 128'(beat_addr[0]), 128'(32'h6000));
      chk("t5_after_row1_el2", 128'(beat_data[1][47:32]), 128'(16'd9));
      chk("t5_tiles_done", 128'(tiles_done), 128'(1));

      // Address wrap
      run_tile(32'hFFFF_FFC0, 32'h10, 5'd0, -1, 0, 1'b0, 32'h0);
      chk("t6_addr3", 128'(beat_addr[3]), 128'(32'hFFFF_FFF0));
      chk("t6_addr4", 128'(beat_addr[4]), 128'(32'h0000_0000));
      chk("t6_addr7", 128'(beat_addr[7]), 128'(32'h0000_0030));
      chk("t6_tiles_done", 128'(tiles_done), 128'(2));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
